// File: rtl/memory_stage_ctrl_pkg.sv
// Shared types and constants for the memory-stage controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memstage_pkg;

  // Default number of request cycles allowed before an access is abandoned.
  localparam int TIMEOUT_DEFAULT = 16;

  // Width of the wait counter; supports TIMEOUT values up to 255.
  localparam int CNT_W = 8;

  // Memory handshake state: IDLE accepts new accesses, BUSY waits on DMREADY.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/memory_stage_ctrl_if.sv
// Pipeline M-stage inputs, data-memory handshake and MEM/WB outputs.
// Latency: n/a (wiring only).
// Backpressure: STALLM from the slave freezes everything the master drives.
interface memory_stage_ctrl_if;

  // M-stage control and data from the EX/MEM register
  logic        REGWRITEM;
  logic        MEMTOREGM;
  logic        MEMWRITEM;
  logic [31:0] ALUOUTPUTM;
  logic [31:0] WRITEDATAM;
  logic [4:0]  WRITEREGM;

  // Data-memory port
  logic        DMREQ;
  logic        DMWE;
  logic [31:0] DMADDR;
  logic [31:0] DMWDATA;
  logic [31:0] DMRDATA;
  logic        DMREADY;

  // Hazard and error strobes
  logic        STALLM;
  logic        ADDRERR;
  logic        TIMEOUTERR;

  // MEM/WB register outputs
  logic        REGWRITEW;
  logic        MEMTOREGW;
  logic [31:0] READDATAW;
  logic [31:0] ALUOUTPUTW;
  logic [4:0]  WRITEREGW;

  // Pipeline/memory side: drives M-stage signals and memory responses
  modport master (
    output REGWRITEM, MEMTOREGM, MEMWRITEM, ALUOUTPUTM, WRITEDATAM, WRITEREGM,
    output DMRDATA, DMREADY,
    input  DMREQ, DMWE, DMADDR, DMWDATA, STALLM, ADDRERR, TIMEOUTERR,
    input  REGWRITEW, MEMTOREGW, READDATAW, ALUOUTPUTW, WRITEREGW
  );

  // Controller side
  modport slave (
    input  REGWRITEM, MEMTOREGM, MEMWRITEM, ALUOUTPUTM, WRITEDATAM, WRITEREGM,
    input  DMRDATA, DMREADY,
    output DMREQ, DMWE, DMADDR, DMWDATA, STALLM, ADDRERR, TIMEOUTERR,
    output REGWRITEW, MEMTOREGW, READDATAW, ALUOUTPUTW, WRITEREGW
  );

endinterface

// File: rtl/memory_stage_ctrl_memwb.sv
// MEM/WB pipeline register with bubble insertion.
// Latency: 1 cycle from inputs to outputs.
// Backpressure: none; a bubble clears the write controls and holds data fields.
module memwb_register (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bubble,
  input  logic        load_rdata,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic [4:0]  writereg_in,
  input  logic [31:0] aluout_in,
  input  logic [31:0] rdata_in,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic [4:0]  writereg_out,
  output logic [31:0] aluout_out,
  output logic [31:0] rdata_out
);

  // Capture the retiring instruction, or kill its register write on a bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      regwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
      writereg_out <= '0;
      aluout_out   <= '0;
      rdata_out    <= '0;
    end else if (bubble) begin
      regwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
    end else begin
      regwrite_out <= regwrite_in;
      memtoreg_out <= memtoreg_in;
      writereg_out <= writereg_in;
      aluout_out   <= aluout_in;
      if (load_rdata) begin
        rdata_out <= rdata_in;
      end
    end
  end

endmodule

// File: rtl/memory_stage_ctrl.sv
// M-stage data-memory controller: request/stall FSM, timeout counter, error strobes.
// Latency: request same cycle (combinational); MEM/WB result one edge after completion.
// Backpressure: STALLM holds upstream while a request waits; timeout drops the access.
module memory_stage_ctrl
  import memstage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic                CLK,
  input logic                RST,
  memory_stage_ctrl_if.slave bus
);

  // Counter value that, once reached without DMREADY, ends the wait
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             access, aligned;
  logic             dmreq, addrerr, tmo, stall, complete, bubble;

  // A load wins when both load and store controls are set
  assign access   = bus.MEMTOREGM | bus.MEMWRITEM;
  assign aligned  = (bus.ALUOUTPUTM[1:0] == 2'b00);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // State and wait-counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next state, counter update and per-cycle request/error decisions
  always_comb begin
    state_n = state_q;
    cnt_n   = '0;
    dmreq   = 1'b0;
    addrerr = 1'b0;
    tmo     = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          if (access) begin
            if (aligned) begin
              dmreq = 1'b1;
              if (!bus.DMREADY) begin
                state_n = BUSY;
              end
            end else begin
              addrerr = 1'b1;
            end
          end
        end
        BUSY: begin
          dmreq = 1'b1;
          if (bus.DMREADY) begin
            state_n = IDLE;
          end else if (cnt_inc == CNT_LAST) begin
            tmo     = 1'b1;
            state_n = IDLE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // The timeout cycle releases the pipeline and drops the access as a bubble
  assign stall    = dmreq & ~bus.DMREADY & ~tmo;
  assign complete = dmreq & bus.DMREADY;
  assign bubble   = stall | tmo | addrerr;

  assign bus.DMREQ      = dmreq;
  assign bus.DMWE       = dmreq & bus.MEMWRITEM & ~bus.MEMTOREGM;
  assign bus.DMADDR     = {bus.ALUOUTPUTM[31:2], 2'b00};
  assign bus.DMWDATA    = bus.WRITEDATAM;
  assign bus.STALLM     = stall;
  assign bus.ADDRERR    = addrerr;
  assign bus.TIMEOUTERR = tmo;

  memwb_register u_memwb (
    .CLK          (CLK),
    .RST          (RST),
    .bubble       (bubble),
    .load_rdata   (complete & bus.MEMTOREGM),
    .regwrite_in  (bus.REGWRITEM),
    .memtoreg_in  (bus.MEMTOREGM),
    .writereg_in  (bus.WRITEREGM),
    .aluout_in    (bus.ALUOUTPUTM),
    .rdata_in     (bus.DMRDATA),
    .regwrite_out (bus.REGWRITEW),
    .memtoreg_out (bus.MEMTOREGW),
    .writereg_out (bus.WRITEREGW),
    .aluout_out   (bus.ALUOUTPUTW),
    .rdata_out    (bus.READDATAW)
  );

endmodule
